edge_toggle_divider: RTL and testbench

- Synchronous replacement for the not_/nand_ glitch edge detector driving a t_trigger.
- Resynchronises a slow asynchronous input `In`, detects its selected edge and emits a one-cycle active-low pulse (`Pulse_n`, the nand_ output analogue).
- Each detected edge advances a chain of toggle stages. `Q[0]` is the t_trigger output (input frequency / 2); higher bits divide further.
- Sits between an external square-wave source and downstream frequency-divided logic.

---
 rtl/edge_toggle_divider.sv | 66 ++++++
 tb/tb_edge_toggle_divider.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/edge_toggle_divider.sv
// Synchronised edge detector feeding a synchronous toggle chain: each accepted
// edge of In emits a one-cycle low on Pulse_n and increments Q (modulo 2^DIV_STAGES).
module edge_toggle_divider #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_STAGES  = 1,
  parameter int EDGE_MODE   = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  In,
  input  logic                  Enable,
  output logic                  Pulse_n,
  output logic [DIV_STAGES-1:0] Q,
  output logic [DIV_STAGES-1:0] Q_inv
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  logic                  w_sync;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_det;
  logic                  w_acc;
  logic [DIV_STAGES-1:0] w_toggle;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;

  always_comb begin
    w_det = w_rise;
    case (EDGE_MODE)
      1:       w_det = w_fall;
      2:       w_det = w_rise | w_fall;
      default: w_det = w_rise;
    endcase
  end

  // Enable gates detection only; a dropped edge is never replayed.
  assign w_acc = w_det & Enable;

  // Stage i flips when every lower stage is about to wrap from ones to zeros,
  // giving a carry-style up-counter with all flops on the same clock.
  assign w_toggle[0] = w_acc;
  for (genvar gi = 1; gi < DIV_STAGES; gi++) begin : g_toggle
    assign w_toggle[gi] = w_acc & (&Q[gi-1:0]);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      Pulse_n <= 1'b1;
      Q       <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], In};
      r_prev  <= w_sync;
      Pulse_n <= ~w_acc;
      Q       <= Q ^ w_toggle;
    end
  end

  assign Q_inv = ~Q;

endmodule

// File: tb/tb_edge_toggle_divider.sv
// Randomised bench for edge_toggle_divider: three configurations share one
// stimulus stream and are checked every cycle against an edge-count model.
module tb_edge_toggle_divider;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic In = 1'b0;
  logic Enable = 1'b1;

  logic       pn0, pn1, pn2;
  logic [2:0] q0, qi0, q1, qi1;
  logic [3:0] q2, qi2;

  // clock / reset block
  always #5 Clock = ~Clock;

  edge_toggle_divider #(.SYNC_STAGES(2), .DIV_STAGES(3), .EDGE_MODE(0)) u_m0 (
    .Clock(Clock), .Reset(Reset), .In(In), .Enable(Enable),
    .Pulse_n(pn0), .Q(q0), .Q_inv(qi0));
  edge_toggle_divider #(.SYNC_STAGES(2), .DIV_STAGES(3), .EDGE_MODE(1)) u_m1 (
    .Clock(Clock), .Reset(Reset), .In(In), .Enable(Enable),
    .Pulse_n(pn1), .Q(q1), .Q_inv(qi1));
  edge_toggle_divider #(.SYNC_STAGES(3), .DIV_STAGES(4), .EDGE_MODE(2)) u_m2 (
    .Clock(Clock), .Reset(Reset), .In(In), .Enable(Enable),
    .Pulse_n(pn2), .Q(q2), .Q_inv(qi2));

  // reference model: In as seen at every edge plus an accepted-edge count
  localparam int NSAMP = 16384;
  localparam int OFS   = 8;
  int         sync_st [3] = '{2, 2, 3};
  int         mode_of [3] = '{0, 1, 2};
  logic [3:0] dmask   [3] = '{4'h7, 4'h7, 4'hF};
  logic       samp [NSAMP];
  int         ne = 0;
  int         cnt [3] = '{0, 0, 0};
  logic       exp_pn [3] = '{1'b1, 1'b1, 1'b1};
  logic       model_valid = 1'b0;
  int         pulses [3] = '{0, 0, 0};

  int n_cmp = 0;
  int n_bad = 0;

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, ne, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  idx;
    logic c, p, det, acc;
    idx = ne + OFS;
    samp[idx] = Reset ? 1'b0 : In;
    if (Reset) begin
      for (int k = 0; k <= 4; k++) samp[idx-k] = 1'b0;
      model_valid = 1'b1;
    end
    for (int j = 0; j < 3; j++) begin
      c = samp[idx - sync_st[j]];
      p = samp[idx - sync_st[j] - 1];
      case (mode_of[j])
        0:       det = c & ~p;
        1:       det = ~c & p;
        default: det = c ^ p;
      endcase
      acc = det & Enable & ~Reset;
      if (Reset) cnt[j] = 0;
      else if (acc) cnt[j] = cnt[j] + 1;
      exp_pn[j] = ~acc;
    end
    ne++;
  endtask

  task automatic compare();
    logic [3:0] eq [3];
    if (!model_valid) return;
    for (int j = 0; j < 3; j++) eq[j] = 4'(cnt[j]) & dmask[j];
    check("m0_pulse_n", {31'd0, pn0}, {31'd0, exp_pn[0]});
    check("m1_pulse_n", {31'd0, pn1}, {31'd0, exp_pn[1]});
    check("m2_pulse_n", {31'd0, pn2}, {31'd0, exp_pn[2]});
    check("m0_q", {29'd0, q0}, {28'd0, eq[0]});
    check("m1_q", {29'd0, q1}, {28'd0, eq[1]});
    check("m2_q", {28'd0, q2}, {28'd0, eq[2]});
    check("m0_q_inv", {29'd0, qi0}, {29'd0, ~eq[0][2:0]});
    check("m1_q_inv", {29'd0, qi1}, {29'd0, ~eq[1][2:0]});
    check("m2_q_inv", {28'd0, qi2}, {28'd0, ~eq[2]});
    if (!pn0) pulses[0]++;
    if (!pn1) pulses[1]++;
    if (!pn2) pulses[2]++;
  endtask

  // driver tasks
  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    compare();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    hold(n);
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NSAMP; i++) samp[i] = 1'b0;

    // reset with In low
    In = 1'b0;
    Enable = 1'b1;
    do_reset(3);
    check("reset_pulse_n", {31'd0, pn0}, 32'd1);
    check("reset_q_inv", {29'd0, qi2[2:0]}, 32'd7);

    // basic divide: ten clean periods
    for (int j = 0; j < 3; j++) pulses[j] = 0;
    for (int p = 0; p < 10; p++) begin
      In = 1'b1; hold(6);
      In = 1'b0; hold(6);
    end
    hold(6);
    check("basic_rise_pulses", pulses[0], 10);
    check("basic_fall_pulses", pulses[1], 10);
    check("basic_both_pulses", pulses[2], 20);

    // wrap: nine more rising edges from zero
    do_reset(2);
    for (int p = 0; p < 9; p++) begin
      In = 1'b1; hold(5);
      In = 1'b0; hold(5);
    end
    check("wrap_q0_final", {29'd0, q0}, 32'd1);

    // reset while In is high: refill yields one counted rise
    for (int p = 0; p < 5; p++) begin
      In = 1'b1; hold(5);
      In = 1'b0; hold(5);
    end
    In = 1'b1; hold(5);
    do_reset(1);
    hold(6);
    check("rst_high_q0", {29'd0, q0}, 32'd1);

    // reset on the same edge as an accepted rise
    In = 1'b0; hold(6);
    In = 1'b1;
    hold(2);
    Reset = 1'b1;
    step();
    check("rst_beats_acc_pn", {31'd0, pn0}, 32'd1);
    check("rst_beats_acc_q", {29'd0, q0}, 32'd0);
    Reset = 1'b0;
    hold(6);

    // enable gating: two of six rising edges dropped
    do_reset(2);
    In = 1'b0; hold(5);
    for (int p = 0; p < 6; p++) begin
      In = 1'b1;
      Enable = (p == 2 || p == 3) ? 1'b0 : 1'b1;
      hold(6);
      Enable = 1'b1;
      In = 1'b0; hold(6);
    end
    check("enable_gate_q0", {29'd0, q0}, 32'd4);

    // randomised run
    for (int s = 0; s < 400; s++) begin
      int len;
      In = ~In;
      len = $urandom_range(4, 12);
      for (int i = 0; i < len; i++) begin
        Enable = ($urandom_range(0, 7) != 0);
        Reset  = ($urandom_range(0, 60) == 0);
        step();
      end
      Reset = 1'b0;
    end
    Enable = 1'b1;
    hold(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
